// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Cleans one raw, bouncy, asynchronous push-button input.
//                A SYNC_STAGES-deep synchronizer feeds a stability counter.
//                The debounced level only follows the synchronized input after
//                it has differed for STABLE_CYCLES consecutive clocks. A
//                registered one-cycle pulse marks each 0->1 transition of the
//                debounced level.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int CNT_WIDTH     = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn_in,
  output logic o_clean_out,
  output logic o_pos_edge
);

  // The last count value before the debounced level is allowed to change.
  // The counter never goes past this value, so it cannot wrap.
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ZERO = '0;

  // Synchronizer chain. Bit 0 samples the raw pin and the top bit is the
  // only value the rest of the block ever looks at.
  logic [SYNC_STAGES-1:0] r_sync;

  // Stability counter and registered outputs.
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_clean;
  logic                   r_pos_edge;

  // Combinational decode of the current stability situation.
  logic                   w_sync;
  logic                   w_differ;
  logic                   w_window_done;
  logic                   w_rise;

  assign w_sync        = r_sync[SYNC_STAGES-1];
  assign w_differ      = w_sync ^ r_clean;
  assign w_window_done = w_differ && (r_cnt == c_CNT_MAX);
  // A completed window moves r_clean to w_sync, so a rise is a completed
  // window while the synchronized level is high.
  assign w_rise        = w_window_done && w_sync;

  // Shift the raw input through the synchronizer flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_in};
    end
  end

  // Count consecutive cycles of disagreement and commit the new level once
  // the full window has elapsed; any agreeing cycle restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= c_CNT_ZERO;
      r_clean <= 1'b0;
    end else if (!w_differ) begin
      r_cnt   <= c_CNT_ZERO;
    end else if (w_window_done) begin
      r_cnt   <= c_CNT_ZERO;
      r_clean <= w_sync;
    end else begin
      r_cnt   <= r_cnt + c_CNT_ONE;
    end
  end

  // Register the rising-edge pulse on the same edge that r_clean goes high;
  // it clears on the next edge because a rise cannot repeat back to back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos_edge <= 1'b0;
    end else begin
      r_pos_edge <= w_rise;
    end
  end

  assign o_clean_out = r_clean;
  assign o_pos_edge  = r_pos_edge;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debouncer
//  Description : Self-checking bench for button_debouncer. Two instances share
//                the button and reset: one with a 4-cycle window and one with
//                a 1-cycle window. A run-length model of the debouncing rule
//                is compared against both every clock, and directed checks pin
//                the documented latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

  localparam int c_SYNC = 2;

  logic clk;
  logic reset;
  logic btn;
  logic clean4, pe4;
  logic clean1, pe1;

  int n_cmp = 0;
  int n_bad = 0;
  int pe4_count = 0;

  button_debouncer #(.SYNC_STAGES(c_SYNC), .STABLE_CYCLES(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .i_btn_in   (btn),
    .o_clean_out(clean4),
    .o_pos_edge (pe4)
  );

  button_debouncer #(.SYNC_STAGES(c_SYNC), .STABLE_CYCLES(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .i_btn_in   (btn),
    .o_clean_out(clean1),
    .o_pos_edge (pe1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: the synchronized level seen before an edge is the button sampled
  // c_SYNC edges earlier (0 if not yet sampled since reset). The clean level
  // flips once the synchronized level has disagreed with it for `window`
  // consecutive edges; a flip to 1 produces a one-edge pulse.
  // ---------------------------------------------------------------------------
  int m_window [2] = '{4, 1};
  int m_run    [2] = '{0, 0};
  bit m_clean  [2] = '{1'b0, 1'b0};
  bit m_pe     [2] = '{1'b0, 1'b0};
  bit hist[$];

  always @(posedge clk or posedge reset) begin : model
    bit syncp;
    if (reset) begin
      hist.delete();
      for (int i = 0; i < 2; i++) begin
        m_run[i]   = 0;
        m_clean[i] = 1'b0;
        m_pe[i]    = 1'b0;
      end
    end else begin
      syncp = (hist.size() >= c_SYNC) ? hist[hist.size() - c_SYNC] : 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_pe[i] = 1'b0;
        if (syncp != m_clean[i]) begin
          m_run[i]++;
          if (m_run[i] == m_window[i]) begin
            m_pe[i]    = syncp;
            m_clean[i] = syncp;
            m_run[i]   = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      hist.push_back(btn);
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  // Compare both instances with the model on every falling edge.
  always @(negedge clk) begin
    check("model clean w4", clean4, m_clean[0]);
    check("model pulse w4", pe4,    m_pe[0]);
    check("model clean w1", clean1, m_clean[1]);
    check("model pulse w1", pe1,    m_pe[1]);
    if (pe4 === 1'b1) pe4_count++;
  end

  // One clock: drive the button on the falling edge, return 1 after the
  // following rising edge.
  task automatic cyc(input logic b);
    @(negedge clk);
    btn = b;
    @(posedge clk);
    #1;
  endtask

  // Release reset on a falling edge; the next rising edge is edge 1.
  task automatic release_rst(input logic b);
    @(negedge clk);
    reset = 1'b0;
    btn   = b;
    @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    reset = 1'b1;
    btn   = 1'b0;
    #2;
    check("reset clean", clean4, 1'b0);
    check("reset pulse", pe4, 1'b0);

    // Idle after reset.
    release_rst(1'b0);
    repeat (19) cyc(1'b0);
    check("idle clean", clean4, 1'b0);
    check_int("idle pulses", pe4_count, 0);

    // Clean press; the 1-cycle window instance covers the minimal case.
    cyc(1'b1); cyc(1'b1); cyc(1'b1);                  // edge 3
    check("w1 clean @3", clean1, 1'b1);
    check("w1 pulse @3", pe1, 1'b1);
    cyc(1'b1);                                         // edge 4
    check("w1 pulse @4", pe1, 1'b0);
    cyc(1'b1);                                         // edge 5
    check("press clean @5", clean4, 1'b0);
    cyc(1'b1);                                         // edge 6
    check("press clean @6", clean4, 1'b1);
    check("press pulse @6", pe4, 1'b1);
    cyc(1'b1);                                         // edge 7
    check("press pulse @7", pe4, 1'b0);
    base = pe4_count;
    repeat (50) cyc(1'b1);
    check("held clean", clean4, 1'b1);
    check_int("held extra pulses", pe4_count - base, 0);

    // Release.
    base = pe4_count;
    repeat (5) cyc(1'b0);
    check("release clean @5", clean4, 1'b1);
    cyc(1'b0);
    check("release clean @6", clean4, 1'b0);
    repeat (10) cyc(1'b0);
    check_int("release pulses", pe4_count - base, 0);

    // Bounce rejection, then a real press.
    base = pe4_count;
    cyc(1'b1); cyc(1'b1); cyc(1'b1); cyc(1'b0);
    cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b0);
    repeat (3) cyc(1'b0);
    check("bounce clean", clean4, 1'b0);
    check_int("bounce pulses", pe4_count - base, 0);
    repeat (5) cyc(1'b1);
    check("bounce press @5", clean4, 1'b0);
    cyc(1'b1);
    check("bounce press @6", clean4, 1'b1);
    check("bounce pulse @6", pe4, 1'b1);
    repeat (20) cyc(1'b1);
    check_int("bounce press pulses", pe4_count - base, 1);

    // Asynchronous reset mid-cycle while the clean level is high.
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async clean w4", clean4, 1'b0);
    check("async clean w1", clean1, 1'b0);
    repeat (2) @(posedge clk);

    // Reset mid-count with the button held.
    release_rst(1'b1);
    repeat (3) cyc(1'b1);
    @(posedge clk);
    #3 reset = 1'b1;
    release_rst(1'b1);                                 // edge 1
    repeat (4) cyc(1'b1);                              // edge 5
    check("midcount clean @5", clean4, 1'b0);
    cyc(1'b1);                                         // edge 6
    check("midcount clean @6", clean4, 1'b1);
    check("midcount pulse @6", pe4, 1'b1);
    repeat (4) cyc(1'b1);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Cleans one raw, bouncy, asynchronous push-button input.
- Produces a stable level output plus a single-cycle rising-edge pulse.
- One instance per button in the Morse-entry front end (dot, dash, done).
- The letter decoder consumes only the edge pulse: one press yields exactly one pulse.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flip-flops on the raw input; legal range ≥ 2.
- STABLE_CYCLES, 1_000_000: consecutive clk cycles the synchronized input must differ from clean_out before clean_out follows it. The default is 10 ms at 100 MHz. Legal range ≥ 1.
- CNT_WIDTH, $clog2(STABLE_CYCLES+1): stability counter width. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_in  input  1  raw button level, asynchronous to clk, may bounce.
- clean_out  output  1  debounced button level (registered).
- pos_edge  output  1  one-clk-cycle pulse marking each 0->1 transition of clean_out (registered).

Behaviour:
- Reset (async, active-high) clears all state immediately:
  - synchronizer flops = 0
  - counter = 0
  - clean_out = 0
  - pos_edge = 0
- While reset is high, outputs hold 0 regardless of btn_in.
- After reset deasserts, operation resumes on the next rising clk edge.
- Synchronizer: btn_in passes through a SYNC_STAGES-deep flop chain; the final stage is "sync". No other logic sees btn_in.
- Counter rules, evaluated each rising edge:
  - sync == clean_out: counter <= 0, clean_out unchanged.
  - sync != clean_out and counter < STABLE_CYCLES-1: counter <= counter+1.
  - sync != clean_out and counter == STABLE_CYCLES-1: clean_out <= sync, counter <= 0.
- Any single cycle where sync equals clean_out restarts the count. Glitches shorter than STABLE_CYCLES cycles (after synchronization) never reach clean_out.
- pos_edge:
  - Registered. Goes 1 on the same edge that clean_out goes 0->1.
  - Returns to 0 on the following edge, so it is exactly one cycle wide.
  - Falling transitions of clean_out never assert pos_edge.
  - Holding the button indefinitely produces one pulse only.
- Latency: if btn_in is high at the first sampling edge (edge 1) and stays high, clean_out and pos_edge go high after edge SYNC_STAGES+STABLE_CYCLES. Release latency to clean_out 1->0 is the same.
- STABLE_CYCLES = 1: clean_out follows sync on the first edge they differ (pure synchronizer + edge detector).
- Counter never exceeds STABLE_CYCLES-1; no wrap-around.
- Reset mid-count discards the partial count. A press in progress must then satisfy the full window again.
- Outputs are glitch-free flop outputs, safe for a consumer sampling on the opposite clock edge.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4 unless noted):
- Reset then idle: assert reset asynchronously mid-cycle -> clean_out=0 and pos_edge=0 immediately; both stay 0 with btn_in=0 for 20 cycles.
- Clean press: btn_in 0->1 before edge 1, held -> clean_out=1 and pos_edge=1 after edge 6; pos_edge=0 after edge 7; clean_out stays 1 and no further pulses over 50 cycles.
- Bounce rejection: from clean_out=0, btn_in toggles 1 for 3 cycles, 0 for 1, 1 for 2, 0 for 2 -> clean_out and pos_edge remain 0 throughout. Then btn_in held 1 -> exactly one pos_edge pulse 6 cycles after the final rise.
- Release: from clean_out=1, btn_in 1->0 held -> clean_out=0 after 6 edges; pos_edge never asserts.
- Reset mid-count: btn_in=1 for 4 cycles (counter partially advanced), pulse reset, btn_in still 1 -> clean_out rises 6 edges after reset release, not earlier.
- Minimal window: STABLE_CYCLES=1, btn_in 0->1 before edge 1 -> clean_out=1 and pos_edge=1 after edge 3; pos_edge cleared after edge 4.
